// File: rtl/gbsha_decim.sv
// gbsha_decim: integrate-and-dump decimator feeding a 2-entry output FIFO.
//   Sums N_DEC signed samples, narrows the sum to BW_out, and queues it for
//   a ready/valid consumer. A result that arrives when the FIFO is full and
//   is not draining in the same cycle is dropped, and the sticky drop flag
//   is set.
// Build option: define GBSHA_DECIM_SAT_EN to saturate the narrowed result.
//   When it is undefined, the low BW_out bits are kept (two's-complement wrap).
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous reset, active low
//   in_valid  - x_in carries a sample this cycle (no backpressure)
//   x_in      - signed input sample, BW_in bits
//   out_valid - FIFO head is valid on y_out
//   out_ready - consumer accepts the head when out_valid is high
//   y_out     - signed decimated sum at the FIFO head, BW_out bits
//   drop      - sticky flag: a result was lost to a full FIFO
//   level     - FIFO occupancy, 0..2
module gbsha_decim #(
  parameter int unsigned N_DEC  = 4,
  parameter int unsigned BW_in  = 3,
  parameter int unsigned BW_out = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BW_in-1:0]  x_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW_out-1:0] y_out,
  output logic              drop,
  output logic [1:0]        level
);

  localparam int unsigned PH_W   = $clog2(N_DEC);
  localparam int unsigned BW_acc = BW_in + PH_W;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_DEC - 1);

  logic [PH_W-1:0]   phase;
  logic [BW_acc-1:0] acc;
  logic [BW_acc-1:0] x_ext;
  logic [BW_acc-1:0] sum;
  logic [BW_out-1:0] result;
  logic [BW_out-1:0] tail;
  logic              push;
  logic              pop;

  logic [BW_out-1:0] y_nxt;
  logic [BW_out-1:0] tail_nxt;
  logic [1:0]        level_nxt;
  logic              drop_nxt;

  // Running sum including the current sample, and its narrowed form.
  always_comb begin
    x_ext = {{(BW_acc - BW_in){x_in[BW_in-1]}}, x_in};
    sum   = acc + x_ext;
`ifdef GBSHA_DECIM_SAT_EN
    // In range only if every bit from the BW_out sign position up matches.
    if ((&sum[BW_acc-1:BW_out-1]) || ~(|sum[BW_acc-1:BW_out-1])) begin
      result = sum[BW_out-1:0];
    end else if (sum[BW_acc-1]) begin
      result = {1'b1, {(BW_out - 1){1'b0}}};
    end else begin
      result = {1'b0, {(BW_out - 1){1'b1}}};
    end
`else
    result = sum[BW_out-1:0];
`endif
  end

  assign push = in_valid && (phase == PH_LAST);
  assign pop  = out_valid && out_ready;

  // FIFO next state: y_out is the head register, tail is the second entry.
  always_comb begin
    y_nxt     = y_out;
    tail_nxt  = tail;
    level_nxt = level;
    drop_nxt  = drop;
    case (level)
      2'd0: begin
        if (push) begin
          y_nxt     = result;
          level_nxt = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b11:   y_nxt = result;
          2'b10: begin
            tail_nxt  = result;
            level_nxt = 2'd2;
          end
          2'b01:   level_nxt = 2'd0;
          default: ;
        endcase
      end
      default: begin
        case ({push, pop})
          2'b11: begin
            y_nxt    = tail;
            tail_nxt = result;
          end
          2'b10:   drop_nxt = 1'b1;
          2'b01: begin
            y_nxt     = tail;
            level_nxt = 2'd1;
          end
          default: ;
        endcase
      end
    endcase
  end

  // Phase/accumulator and FIFO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= '0;
      acc       <= '0;
      y_out     <= '0;
      tail      <= '0;
      level     <= 2'd0;
      drop      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        if (phase == PH_LAST) begin
          phase <= '0;
          acc   <= '0;
        end else begin
          phase <= phase + PH_W'(1);
          acc   <= sum;
        end
      end
      y_out     <= y_nxt;
      tail      <= tail_nxt;
      level     <= level_nxt;
      drop      <= drop_nxt;
      out_valid <= (level_nxt != 2'd0);
    end
  end

endmodule

// File: tb/tb_gbsha_decim.sv
// Directed bench for gbsha_decim at default parameters.
module tb_gbsha_decim;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [2:0] x_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y_out;
  logic       drop;
  logic [1:0] level;

  int passed;
  int total;

`ifdef GBSHA_DECIM_SAT_EN
  localparam logic [3:0] EXP_POS12 = 4'b0111;
  localparam logic [3:0] EXP_NEG16 = 4'b1000;
  localparam logic [3:0] EXP_POS8  = 4'b0111;
`else
  localparam logic [3:0] EXP_POS12 = 4'b1100;
  localparam logic [3:0] EXP_NEG16 = 4'b0000;
  localparam logic [3:0] EXP_POS8  = 4'b1000;
`endif

  gbsha_decim #(.N_DEC(4), .BW_in(3), .BW_out(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .drop      (drop),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] v);
    in_valid = 1'b1;
    x_in     = v;
    tick();
    in_valid = 1'b0;
    x_in     = 3'b111;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    x_in      = 3'b000;
    out_ready = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
    total++; if (y_out !== 4'd0) $display("FAIL reset_y got=%h exp=0", y_out); else passed++;
    total++; if (level !== 2'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
    total++; if (drop !== 1'b0) $display("FAIL reset_drop got=%b exp=0", drop); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(3'd1); send(3'd1); send(3'd1);
    total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got=%b exp=0", out_valid); else passed++;
    send(3'd1);
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else passed++;
    total++; if (y_out !== 4'd4) $display("FAIL basic_y got=%h exp=4", y_out); else passed++;
    total++; if (level !== 2'd1) $display("FAIL basic_level got=%0d exp=1", level); else passed++;
    tick();
    total++; if (level !== 2'd0) $display("FAIL basic_pop_level got=%0d exp=0", level); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_pop_valid got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_narrow();
    out_ready = 1'b1;
    send(3'd3); send(3'd3); send(3'd3); send(3'd3);
    total++; if (y_out !== EXP_POS12) $display("FAIL narrow_pos got=%b exp=%b", y_out, EXP_POS12); else passed++;
    tick();
    send(3'b100); send(3'b100); send(3'b100); send(3'b100);
    total++; if (out_valid !== 1'b1) $display("FAIL narrow_neg_valid got=%b exp=1", out_valid); else passed++;
    total++; if (y_out !== EXP_NEG16) $display("FAIL narrow_neg got=%b exp=%b", y_out, EXP_NEG16); else passed++;
    tick();
  endtask

  // Samples with gaps; x_in carries junk while in_valid is low.
  task automatic test_gaps();
    out_ready = 1'b1;
    send(3'd1); idle(2);
    send(3'd2); idle(1);
    send(3'b111);
    total++; if (out_valid !== 1'b0) $display("FAIL gaps_early_valid got=%b exp=0", out_valid); else passed++;
    send(3'd1);
    total++; if (y_out !== 4'd3) $display("FAIL gaps_sum got=%h exp=3", y_out); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(3'd1);
    total++; if (level !== 2'd2) $display("FAIL bp_level2 got=%0d exp=2", level); else passed++;
    total++; if (drop !== 1'b0) $display("FAIL bp_nodrop got=%b exp=0", drop); else passed++;
    for (int i = 0; i < 4; i++) send(3'd1);
    total++; if (drop !== 1'b1) $display("FAIL bp_drop got=%b exp=1", drop); else passed++;
    total++; if (level !== 2'd2) $display("FAIL bp_level_full got=%0d exp=2", level); else passed++;
    total++; if (y_out !== 4'd4) $display("FAIL bp_head got=%h exp=4", y_out); else passed++;
    out_ready = 1'b1;
    tick();
    total++; if (y_out !== 4'd4) $display("FAIL bp_second got=%h exp=4", y_out); else passed++;
    total++; if (level !== 2'd1) $display("FAIL bp_level1 got=%0d exp=1", level); else passed++;
    tick();
    total++; if (level !== 2'd0) $display("FAIL bp_level0 got=%0d exp=0", level); else passed++;
    total++; if (drop !== 1'b1) $display("FAIL bp_drop_sticky got=%b exp=1", drop); else passed++;
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    tick();
    total++; if (drop !== 1'b0) $display("FAIL b2b_drop_cleared got=%b exp=0", drop); else passed++;
    out_ready = 1'b0;
    send(3'd1); send(3'd1); send(3'd1); send(3'd1);
    send(3'd1); send(3'd0); send(3'd0); send(3'd0);
    total++; if (level !== 2'd2) $display("FAIL b2b_full got=%0d exp=2", level); else passed++;
    send(3'd0); send(3'd0); send(3'd0);
    out_ready = 1'b1;
    send(3'd2);
    total++; if (level !== 2'd2) $display("FAIL b2b_level got=%0d exp=2", level); else passed++;
    total++; if (drop !== 1'b0) $display("FAIL b2b_drop got=%b exp=0", drop); else passed++;
    total++; if (y_out !== 4'd1) $display("FAIL b2b_head got=%h exp=1", y_out); else passed++;
    tick();
    total++; if (y_out !== 4'd2) $display("FAIL b2b_tail got=%h exp=2", y_out); else passed++;
    tick();
    total++; if (level !== 2'd0) $display("FAIL b2b_empty got=%0d exp=0", level); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(3'd1); send(3'd1); send(3'd1); send(3'd1);
    send(3'd2); send(3'd2);
    total++; if (level !== 2'd1) $display("FAIL rmid_pre_level got=%0d exp=1", level); else passed++;
    #2;
    reset = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", out_valid); else passed++;
    total++; if (y_out !== 4'd0) $display("FAIL rmid_y got=%h exp=0", y_out); else passed++;
    total++; if (level !== 2'd0) $display("FAIL rmid_level got=%0d exp=0", level); else passed++;
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    send(3'd2); send(3'd2); send(3'd2);
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_phase got=%b exp=0", out_valid); else passed++;
    send(3'd2);
    total++; if (y_out !== EXP_POS8) $display("FAIL rmid_sum got=%b exp=%b", y_out, EXP_POS8); else passed++;
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic();
    test_narrow();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
